// File: rtl/ram_bank_ctrl_pkg.sv
// Shared definitions for the RAM bank controller: default widths, FSM encoding
// and the self-test patterns.
package ram_bank_ctrl_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned BANKS_DEF  = 4;
  localparam int unsigned ADDR_W_DEF = 2;

  localparam logic [7:0] BIST_PAT0 = 8'h55;
  localparam logic [7:0] BIST_PAT1 = 8'hAA;

  // S_BGAP is the inter-access slot of the self-test sequence
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_ACK   = 3'd3,
    S_BGAP  = 3'd4
  } state_e;

endpackage

// File: rtl/ram_bank_ctrl_if.sv
// Host-side request/acknowledge bus of the RAM bank controller.
interface ram_bank_ctrl_if
  import ram_bank_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (output req, we, addr, wdata, input ack, err, rdata, busy);
  modport slave  (input req, we, addr, wdata, output ack, err, rdata, busy);
endinterface

// File: rtl/ram_bank_ctrl_bank_decode.sv
// Bank index to one-hot select, with an out-of-range flag for indices >= BANKS.
module bank_decode #(
  parameter int unsigned BANKS  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [BANKS-1:0]  sel_c,
  output logic              oor_c
);
  always_comb begin
    sel_c = '0;
    oor_c = (32'(addr) >= BANKS);
    for (int unsigned i = 0; i < BANKS; i++) begin
      if (32'(addr) == i) sel_c[i] = 1'b1;
    end
  end
endmodule

// File: rtl/ram_bank_ctrl.sv
// Single-access initiator for the one-word RAM banks (req/ack host side).
// Define RAM_BANK_CTRL_BIST_EN to compile in the 55/AA pattern self-test.
module ram_bank_ctrl
  import ram_bank_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned BANKS  = BANKS_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  ram_bank_ctrl_if.slave    host,
  output logic [BANKS-1:0]  ram_sel,
  output logic              ram_rw,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q,
  input  logic              bist_start,
  output logic              bist_done,
  output logic              bist_fail
);

`ifdef RAM_BANK_CTRL_BIST_EN
  localparam bit BIST_EN = 1'b1;
`else
  localparam bit BIST_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              bist_q, bist_d;
  logic              bist_done_q, bist_done_d;
  logic              bist_fail_q, bist_fail_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [BANKS-1:0]  sel_q, sel_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] ram_data_q, ram_data_d;
  logic [BANKS-1:0]  dec_sel_c;
  logic              dec_oor_c;

  // Decode the upcoming bank index so the select flops line up with the state
  bank_decode #(.BANKS(BANKS), .ADDR_W(ADDR_W)) u_bank_decode (
    .addr  (addr_d),
    .sel_c (dec_sel_c),
    .oor_c (dec_oor_c)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    bist_d      = bist_q;
    bist_done_d = bist_done_q;
    bist_fail_d = bist_fail_q;
    case (state_q)
      S_IDLE: begin
        if (BIST_EN && bist_start) begin
          bist_d      = 1'b1;
          bist_done_d = 1'b0;
          bist_fail_d = 1'b0;
          we_d        = 1'b1;
          addr_d      = '0;
          wdata_d     = DATA_W'(BIST_PAT0);
          state_d     = S_WRITE;
        end else if (host.req) begin
          we_d    = host.we;
          addr_d  = host.addr;
          wdata_d = host.wdata;
          state_d = host.we ? S_WRITE : S_READ;
        end
      end
      S_WRITE: state_d = bist_q ? S_BGAP : S_ACK;
      S_READ: begin
        if (bist_q && (ram_q != wdata_q)) bist_fail_d = 1'b1;
        state_d = bist_q ? S_BGAP : S_ACK;
      end
      S_ACK: state_d = S_IDLE;
      // Self-test order per bank: W55, R55, WAA, RAA, then next bank
      S_BGAP: begin
        if (we_q) begin
          we_d    = 1'b0;
          state_d = S_READ;
        end else if (wdata_q == DATA_W'(BIST_PAT0)) begin
          we_d    = 1'b1;
          wdata_d = DATA_W'(BIST_PAT1);
          state_d = S_WRITE;
        end else if (addr_q == ADDR_W'(BANKS - 1)) begin
          bist_d      = 1'b0;
          bist_done_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          we_d    = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          wdata_d = DATA_W'(BIST_PAT0);
          state_d = S_WRITE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs derived from the next state
  always_comb begin
    ack_d      = (state_d == S_ACK);
    err_d      = (state_d == S_ACK) && dec_oor_c;
    busy_d     = (state_d != S_IDLE);
    sel_d      = '0;
    rw_d       = 1'b0;
    ram_data_d = ram_data_q;
    rdata_d    = rdata_q;
    if (((state_d == S_WRITE) || (state_d == S_READ)) && !dec_oor_c) sel_d = dec_sel_c;
    if (state_d == S_WRITE) begin
      ram_data_d = wdata_d;
      rw_d       = !dec_oor_c;
    end
    if ((state_q == S_READ) && !bist_q) rdata_d = dec_oor_c ? '0 : ram_q;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      bist_q      <= 1'b0;
      bist_done_q <= 1'b0;
      bist_fail_q <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      rdata_q     <= '0;
      sel_q       <= '0;
      rw_q        <= 1'b0;
      ram_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      bist_q      <= bist_d;
      bist_done_q <= bist_done_d;
      bist_fail_q <= bist_fail_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      rdata_q     <= rdata_d;
      sel_q       <= sel_d;
      rw_q        <= rw_d;
      ram_data_q  <= ram_data_d;
    end
  end

  assign host.ack   = ack_q;
  assign host.err   = err_q;
  assign host.busy  = busy_q;
  assign host.rdata = rdata_q;
  assign ram_sel    = sel_q;
  assign ram_rw     = rw_q;
  assign ram_data   = ram_data_q;
  assign bist_done  = bist_done_q;
  assign bist_fail  = bist_fail_q;

endmodule

// File: doc/ram_bank_ctrl.md
# ram_bank_ctrl

Synchronous initiator for the JK-flip-flop RAM banks: accepts single read/write requests from a host on a req/ack handshake and drives bank select, rw and write data to a bank array. It captures the selected bank's output and returns it to the host. Sits between the datapath/test bench and a RAM array of BANKS x DATA_W words, one word per bank. An optional built-in pattern self-test can be compiled in.

## Interface
- DATA_W, 8, word width; matches bank data width
- BANKS, 4, number of banks (one word each)
- ADDR_W, 2, host address width; 2^ADDR_W >= BANKS
- clk  in  1  clock; all state changes on rising edge
- clr  in  1  reset, asynchronous, active-high
- req  in  1  host request, sampled in IDLE only
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  ADDR_W  bank index
- wdata  in  DATA_W  write data, sampled with req
- ack  out  1  one-cycle completion pulse
- err  out  1  valid with ack; 1 = addr >= BANKS
- rdata  out  DATA_W  read result, valid with ack; holds until next read
- busy  out  1  1 whenever state != IDLE
- ram_sel  out  BANKS  one-hot bank select (bank address input)
- ram_rw  out  1  bank write enable
- ram_data  out  DATA_W  bank write data
- ram_q  in  DATA_W  OR of all bank outputs (unselected banks output 0)
- bist_start  in  1  start self-test (see Configuration)
- bist_done  out  1  self-test finished, sticky until next start or clr
- bist_fail  out  1  self-test mismatch seen, valid with bist_done

## Operation
- FSM states: IDLE, WRITE, READ, ACK (plus BIST sequencing when compiled in).
- IDLE: req=1 latches we/addr/wdata; we=1 -> WRITE, we=0 -> READ.
- WRITE: ram_sel = onehot(addr), ram_rw=1, ram_data=wdata for exactly one full cycle -> ACK.
- READ: ram_sel = onehot(addr), ram_rw=0; at the end of the cycle ram_q is captured into rdata -> ACK.
- ACK: ack=1, err per latched addr; ram_sel=0, ram_rw=0 -> IDLE.
- addr >= BANKS: ram_sel stays 0 (no bank touched), write dropped, read returns rdata=0, ack with err=1.
- req while busy: ignored, not queued; host re-asserts after ack.
- ram_data holds the last write value when not writing; only ram_sel/ram_rw qualify it.

## Timing
- Reset (async): state IDLE; ack, err, busy, ram_sel, ram_rw, bist_done, bist_fail = 0; rdata, ram_data = 0. An access in flight is abandoned with no ack; bank contents are not touched by the controller.
- All outputs registered; they change only on rising clk edges (except async reset).
- Latency: req sampled at edge N -> WRITE/READ during cycle N+1 -> ack high during cycle N+2. Throughput is one access per 3 cycles (req may be re-asserted in the ACK cycle; it is sampled once back in IDLE).
- ram_rw and ram_sel are never high outside WRITE/READ; ram_rw=1 coincides with exactly one ram_sel bit for exactly one cycle.

## Configuration
- RAM_BANK_CTRL_BIST_EN defined: bist_start in IDLE (priority over req when both are high) runs, for bank 0..BANKS-1: write 8'h55, read and compare, write 8'hAA, read and compare, using the WRITE/READ states with no ack pulses. Any mismatch sets bist_fail. At the end, bist_done=1 and the FSM returns to IDLE; busy=1 throughout. Banks are left holding 8'hAA.
- Not defined: bist_start is ignored; bist_done and bist_fail are tied to 0; ports are retained.

## Structure
- Shared package/header: FSM state encoding, BIST patterns 8'h55/8'hAA, default widths.
- One sub-module: bank_decode (ADDR_W -> one-hot BANKS plus out-of-range flag), combinational.

## Test plan
- clr pulse mid-WRITE (after req accepted) -> all outputs 0 next instant, no ack, bank 1 is unchanged from its prior value.
- Write addr=2, wdata=8'h0C; then read addr=2 -> ram_sel=4'b0100 with ram_rw=1 for one cycle; ack 2 cycles after each req; rdata=8'h0C, err=0.
- Write 8'hAA to bank 0 and 8'h0A to bank 3; read both -> rdata 8'hAA then 8'h0A; banks 1/2 are never selected.
- BANKS=3, read addr=3 -> ram_sel stays 0, ack with err=1, rdata=0.
- req held high continuously for 10 cycles -> exactly 3 accesses, with ack on cycles 2, 5 and 8 and busy low only in the IDLE cycles.
- BIST_EN, healthy banks: bist_start -> 8*BANKS busy cycles, then bist_done=1, bist_fail=0; with bank 1 bit 0 forced stuck-at-0 -> bist_fail=1.
